emisor: RTL and testbench

- Serial command transmitter; sits directly upstream of the serial receiver that decodes 3-bit vending commands from an sdain/sclin pair.
- Accepts a 3-bit command code with a start strobe and serializes it MSB-first onto sdaout, with a gated serial clock on sclout.
- Each frame has 4 sclout rising edges: 3 data bits plus 1 terminal edge, which returns the receiver to its idle state.
- Command codes: 001 option A, 010 option B, 011 pay, 100 cancel, 101 out of stock, 110 thank-you. Codes 000 and 111 are illegal; the receiver would hang on them.

---
 rtl/emisor_if.sv | 20 ++
 rtl/emisor.sv | 114 +++++++++++
 tb/tb_emisor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/emisor_if.sv
// rtl/emisor_if.sv - command/serial signal bundle between the command source and emisor
interface emisor_if;
    logic       start;
    logic [2:0] code;
    logic       busy;
    logic       done;
    logic       err;
    logic       sdaout;
    logic       sclout;

    modport master (
        output start, code,
        input  busy, done, err, sdaout, sclout
    );

    modport slave (
        input  start, code,
        output busy, done, err, sdaout, sclout
    );
endinterface

// File: rtl/emisor.sv
// rtl/emisor.sv - serializes a 3-bit command MSB-first on sdaout with a gated sclout
module emisor #(
    parameter int DIV = 4
) (
    input  logic     clk,
    input  logic     reset,
    emisor_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    bit_q, bit_d;
    logic [2:0]    shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sda_q, sda_d;
    logic          scl_q, scl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sda_q   <= 1'b0;
            scl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sda_q   <= sda_d;
            scl_q   <= scl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        sda_d   = sda_q;
        scl_d   = scl_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // 000 and 111 would hang the receiver, so they are refused
                    if (bus.code != 3'b000 && bus.code != 3'b111) begin
                        state_d = LOW;
                        phase_d = '0;
                        bit_d   = '0;
                        busy_d  = 1'b1;
                        scl_d   = 1'b0;
                        sda_d   = bus.code[2];
                        shift_d = {bus.code[1:0], 1'b0};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOW: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    scl_d   = 1'b1;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    scl_d   = 1'b0;
                    // data only moves on the falling edge; the zero shifted in is the terminal bit
                    if (bit_q != 2'd3) begin
                        bit_d   = bit_q + 1'b1;
                        sda_d   = shift_q[2];
                        shift_d = {shift_q[1:0], 1'b0};
                        state_d = LOW;
                    end else begin
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sda_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.sdaout = sda_q;
    assign bus.sclout = scl_q;
endmodule

// File: tb/tb_emisor.sv
// tb/tb_emisor.sv - randomized self-checking bench for emisor with a receiver model
module tb_emisor;
    localparam int DA = 2;
    localparam int DB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ra, rb;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    emisor_if ia();
    emisor_if ib();
    emisor #(.DIV(DA)) u_a (.clk(clk), .reset(ra), .bus(ia));
    emisor #(.DIV(DB)) u_b (.clk(clk), .reset(rb), .bus(ib));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // receiver: three rises shift a code in, the fourth returns it to idle
    logic       rx_rst = 1'b0;
    int         rx_n = 0;
    logic [2:0] rx_sh = '0;
    logic [2:0] rx_data = '0;
    always @(posedge ia.sclout or posedge rx_rst) begin
        if (rx_rst) begin
            rx_n = 0; rx_sh = '0; rx_data = '0;
        end else if (rx_n < 3) begin
            rx_sh = {rx_sh[1:0], ia.sdaout};
            rx_n++;
            if (rx_n == 3) rx_data = rx_sh;
        end else begin
            rx_n = 0; rx_sh = '0; rx_data = '0;
        end
    end

    int   a_rt[$], a_rb[$], a_rx[$], a_dt[$];
    int   b_rt[$], b_rb[$], b_dt[$];
    int   a_busy, a_errn, a_both, b_busy;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    always @(negedge clk) begin
        if (ia.sclout && !a_prev) begin
            a_rt.push_back(cyc); a_rb.push_back(int'(ia.sdaout)); a_rx.push_back(int'(rx_data));
        end
        a_prev = ia.sclout;
        if (ia.busy) a_busy++;
        if (ia.done) a_dt.push_back(cyc);
        if (ia.err) a_errn++;
        if (ia.err && ia.done) a_both++;
        if (ib.sclout && !b_prev) begin
            b_rt.push_back(cyc); b_rb.push_back(int'(ib.sdaout));
        end
        b_prev = ib.sclout;
        if (ib.busy) b_busy++;
        if (ib.done) b_dt.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        a_rt.delete(); a_rb.delete(); a_rx.delete(); a_dt.delete();
        b_rt.delete(); b_rb.delete(); b_dt.delete();
        a_busy = 0; a_errn = 0; a_both = 0; b_busy = 0;
    endtask

    task automatic wait_done_a(input int n, input int budget);
        int t = 0;
        while (a_dt.size() < n && t < budget) begin tick(); t++; end
        if (a_dt.size() < n) check("done_timeout_a", 0, 1);
    endtask

    // s: cycle count when start was driven; frame edges follow from E0 = next clock edge
    task automatic check_frame_a(input string tag, input logic [2:0] c, input int s,
                                 input int j0, input int dn);
        logic [3:0] e;
        e = {c, 1'b0};
        if (a_rt.size() >= j0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, "_rise_t"}, a_rt[j0+k], s + 1 + DA * (2*k + 1));
                check({tag, "_bit"}, a_rb[j0+k], int'(e[3-k]));
            end
            check({tag, "_rx_3rd"}, a_rx[j0+2], int'(c));
            check({tag, "_rx_4th"}, a_rx[j0+3], 0);
        end else begin
            check({tag, "_rise_cnt"}, a_rt.size(), j0 + 4);
        end
        if (a_dt.size() > dn) check({tag, "_done_t"}, a_dt[dn], s + 1 + 8*DA);
        else check({tag, "_done_cnt"}, a_dt.size(), dn + 1);
    endtask

    task automatic frame_a(input logic [2:0] c, input string tag);
        int s;
        clear_mon();
        ia.code = c; ia.start = 1'b1; s = cyc;
        tick();
        ia.start = 1'b0;
        wait_done_a(1, 12*DA + 10);
        tick();
        check_frame_a(tag, c, s, 0, 0);
        check({tag, "_rises"}, a_rt.size(), 4);
        check({tag, "_busy_cyc"}, a_busy, 8*DA);
        check({tag, "_err"}, a_errn, 0);
        check({tag, "_rx_idle"}, rx_n, 0);
    endtask

    initial begin
        int s, t;
        logic [2:0] c;
        ra = 1'b1; rb = 1'b1;
        ia.start = 1'b0; ia.code = 3'b000;
        ib.start = 1'b0; ib.code = 3'b000;
        rx_rst = 1'b1;
        tick(); tick();
        rx_rst = 1'b0;
        check("rst_busy", int'(ia.busy), 0);
        check("rst_done", int'(ia.done), 0);
        check("rst_err", int'(ia.err), 0);
        check("rst_sda", int'(ia.sdaout), 0);
        check("rst_scl", int'(ia.sclout), 0);
        check("rst_scl_b", int'(ib.sclout), 0);
        ra = 1'b0; rb = 1'b0;
        tick();

        for (int i = 1; i <= 6; i++) frame_a(3'(i), "code");

        for (int i = 0; i < 2; i++) begin
            clear_mon();
            ia.code = (i == 0) ? 3'b000 : 3'b111; ia.start = 1'b1;
            tick();
            ia.start = 1'b0;
            repeat (10) tick();
            check("illegal_err", a_errn, 1);
            check("illegal_rises", a_rt.size(), 0);
            check("illegal_busy", a_busy, 0);
            check("illegal_done", a_dt.size(), 0);
        end

        // DIV=4 frame with ignored starts while busy
        clear_mon();
        ib.code = 3'b011; ib.start = 1'b1; s = cyc;
        tick();
        ib.start = 1'b0; ib.code = 3'b100;
        repeat (4) tick();
        ib.start = 1'b1; tick(); ib.start = 1'b0;
        repeat (14) tick();
        ib.start = 1'b1; tick(); ib.start = 1'b0;
        repeat (30) tick();
        check("ign_rises", b_rt.size(), 4);
        if (b_rt.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("ign_rise_t", b_rt[k], s + 1 + DB * (2*k + 1));
                check("ign_bit", b_rb[k], (k == 1 || k == 2) ? 1 : 0);
            end
        end
        check("ign_done_cnt", b_dt.size(), 1);
        if (b_dt.size() >= 1) check("ign_done_t", b_dt[0], s + 1 + 8*DB);
        check("ign_busy_cyc", b_busy, 8*DB);

        // start held high across two frames
        clear_mon();
        ia.code = 3'b101; ia.start = 1'b1; s = cyc;
        t = 0;
        while (!ia.done && t < 12*DA + 10) begin tick(); t++; end
        if (!ia.done) check("b2b_timeout", 0, 1);
        tick();
        ia.start = 1'b0;
        wait_done_a(2, 12*DA + 10);
        repeat (3) tick();
        check("b2b_rises", a_rt.size(), 8);
        check_frame_a("b2b_f1", 3'b101, s, 0, 0);
        check_frame_a("b2b_f2", 3'b101, s + 8*DA + 1, 4, 1);
        if (a_rt.size() >= 5) check("b2b_low_gap", a_rt[4] - (a_rt[3] + DA), DA + 1);
        check("b2b_busy_cyc", a_busy, 16*DA);

        // reset after the second rise aborts the frame
        clear_mon();
        ia.code = 3'b110; ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        t = 0;
        while (a_rt.size() < 2 && t < 8*DA + 10) begin tick(); t++; end
        check("abort_2nd_rise", a_rt.size(), 2);
        ra = 1'b1;
        tick();
        check("abort_busy", int'(ia.busy), 0);
        check("abort_scl", int'(ia.sclout), 0);
        check("abort_sda", int'(ia.sdaout), 0);
        ra = 1'b0;
        repeat (12*DA) tick();
        check("abort_rises", a_rt.size(), 2);
        check("abort_done", a_dt.size(), 0);
        rx_rst = 1'b1; tick(); rx_rst = 1'b0;
        frame_a(3'b001, "after_abort");

        for (int i = 0; i < 8; i++) begin
            c = 3'($urandom_range(1, 6));
            repeat ($urandom_range(0, 5)) tick();
            frame_a(c, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
